// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg
//   Shared types and helpers for priority_encoder_pipe.
//   - penc_highest : highest set index of a vector plus a found flag
//   - penc_onehot  : index to one-hot decode
//   Helpers operate on a fixed maximum width (PENC_MAX_N); callers zero-extend
//   narrower vectors, so request widths up to PENC_MAX_N are supported.

package priority_encoder_pkg;

    localparam int PENC_MAX_N = 64;
    localparam int PENC_MAX_W = 6;

    typedef struct packed {
        logic                  found;
        logic [PENC_MAX_W-1:0] idx;
    } penc_find_t;

    // Ascending scan where the last set bit seen wins, i.e. the highest index.
    function automatic penc_find_t penc_highest(input logic [PENC_MAX_N-1:0] vec);
        penc_find_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < PENC_MAX_N; i++) begin
            if (vec[i]) begin
                r.found = 1'b1;
                r.idx   = PENC_MAX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [PENC_MAX_N-1:0] penc_onehot(input logic [PENC_MAX_W-1:0] idx);
        logic [PENC_MAX_N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/priority_find.sv
// priority_find
//   Combinational highest-set-bit search over (vec_i & mask_i).
//   Ports:
//     vec_i   [N]  request vector
//     mask_i  [N]  bits allowed to take part in the search
//     idx_o   [W]  highest set index among the allowed bits (0 if none)
//     found_o      at least one allowed bit is set

module priority_find
    import priority_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec_i,
    input  logic [N-1:0] mask_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    logic [PENC_MAX_N-1:0] search;
    penc_find_t            res;

    // Bits at or above N are forced to zero, so an index >= N can never win.
    always_comb begin
        search        = '0;
        search[N-1:0] = vec_i & mask_i;
        res           = penc_highest(search);
    end

    assign idx_o   = W'(res.idx);
    assign found_o = res.found;

endmodule

// File: rtl/priority_encoder_pipe.sv
// priority_encoder_pipe
//   Registered priority encoder with valid/ready on both sides. Each accepted
//   request vector yields one result one cycle later in a single-entry output
//   register. A full register can drain and refill in the same cycle.
//
//   Build option: PENC_ROUND_ROBIN_EN
//     undefined : fixed priority, highest set index wins
//     defined   : rotating priority via pointer ptr; indices below ptr are
//                 searched first (highest first), otherwise the whole vector.
//                 ptr follows the last non-zero grant.
//
//   Ports:
//     clk         clock, rising edge
//     rst         synchronous active-high reset
//     req_valid   request vector presented
//     req_ready   block can accept this cycle (!out_valid || out_ready)
//     req   [N]   request vector
//     out_valid   result register holds a result
//     out_ready   consumer takes the result this cycle
//     out_idx [W] granted index
//     out_onehot [N] one-hot grant, zero when out_none
//     out_none    accepted vector was all zeros

module priority_encoder_pipe
    import priority_encoder_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_none
);

    logic         valid_q;
    logic [W-1:0] idx_q,    idx_d;
    logic [N-1:0] onehot_q, onehot_d;
    logic         none_q,   none_d;

    logic         accept;
    logic [W-1:0] grant_idx;
    logic         grant_found;

    assign req_ready = !valid_q || out_ready;
    assign accept    = req_valid && req_ready && !rst;

`ifdef PENC_ROUND_ROBIN_EN
    logic [W-1:0] ptr_q;
    logic [N-1:0] mask_lo;
    logic [W-1:0] idx_lo,   idx_all;
    logic         found_lo, found_all;

    always_comb begin
        mask_lo = '0;
        for (int i = 0; i < N; i++) begin
            mask_lo[i] = (i < int'(ptr_q));
        end
    end

    priority_find #(.N(N)) u_find_lo (
        .vec_i   (req),
        .mask_i  (mask_lo),
        .idx_o   (idx_lo),
        .found_o (found_lo)
    );

    priority_find #(.N(N)) u_find_all (
        .vec_i   (req),
        .mask_i  ({N{1'b1}}),
        .idx_o   (idx_all),
        .found_o (found_all)
    );

    // Any hit below ptr also means the full vector is non-zero.
    assign grant_idx   = found_lo ? idx_lo : idx_all;
    assign grant_found = found_all;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (accept && grant_found) begin
            ptr_q <= grant_idx;
        end
    end
`else
    priority_find #(.N(N)) u_find (
        .vec_i   (req),
        .mask_i  ({N{1'b1}}),
        .idx_o   (grant_idx),
        .found_o (grant_found)
    );
`endif

    always_comb begin
        idx_d    = '0;
        onehot_d = '0;
        none_d   = 1'b1;
        if (grant_found) begin
            idx_d    = grant_idx;
            onehot_d = N'(penc_onehot(PENC_MAX_W'(grant_idx)));
            none_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            idx_q    <= '0;
            onehot_q <= '0;
            none_q   <= 1'b0;
        end else begin
            if (accept) begin
                valid_q  <= 1'b1;
                idx_q    <= idx_d;
                onehot_q <= onehot_d;
                none_q   <= none_d;
            end else if (out_ready) begin
                valid_q  <= 1'b0;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_idx    = idx_q;
    assign out_onehot = onehot_q;
    assign out_none   = none_q;

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Scoreboard bench for priority_encoder_pipe (N=8 and N=5 instances).
// Expectations track PENC_ROUND_ROBIN_EN so either build can be checked.

module tb_priority_encoder_pipe;

    typedef struct packed {
        logic       none;
        logic [2:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       rv8 = 1'b0, ordy8 = 1'b1;
    logic [7:0] req8 = '0;
    logic       rr8, ov8, none8;
    logic [2:0] idx8;
    logic [7:0] oh8;

    logic       rv5 = 1'b0, ordy5 = 1'b1;
    logic [4:0] req5 = '0;
    logic       rr5, ov5, none5;
    logic [2:0] idx5;
    logic [4:0] oh5;

    exp_t q8[$];
    exp_t q5[$];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    priority_encoder_pipe #(.N(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv8),
        .req_ready  (rr8),
        .req        (req8),
        .out_valid  (ov8),
        .out_ready  (ordy8),
        .out_idx    (idx8),
        .out_onehot (oh8),
        .out_none   (none8)
    );

    priority_encoder_pipe #(.N(5)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (rv5),
        .req_ready  (rr5),
        .req        (req5),
        .out_valid  (ov5),
        .out_ready  (ordy5),
        .out_idx    (idx5),
        .out_onehot (oh5),
        .out_none   (none5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitors: compare each result the consumer actually takes.
    always @(negedge clk) begin
        if (!rst && ov8 && ordy8) begin
            if (q8.size() == 0) begin
                chk("n8_unexpected_result", {28'd0, none8, idx8}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                logic [7:0] eoh;
                e   = q8.pop_front();
                eoh = e.none ? 8'h00 : (8'h01 << e.idx);
                chk("n8_result", {11'd0, oh8, 8'd0, none8, idx8}, {11'd0, eoh, 8'd0, e.none, e.idx});
            end
        end
        if (!rst && ov5 && ordy5) begin
            if (q5.size() == 0) begin
                chk("n5_unexpected_result", {28'd0, none5, idx5}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                logic [4:0] eoh;
                e   = q5.pop_front();
                eoh = e.none ? 5'h00 : (5'h01 << e.idx);
                chk("n5_result", {14'd0, oh5, 8'd0, none5, idx5}, {14'd0, eoh, 8'd0, e.none, e.idx});
            end
        end
    end

    task automatic issue8(input logic [7:0] v, input int eidx);
        exp_t e;
        e.none = (eidx < 0);
        e.idx  = (eidx < 0) ? 3'd0 : 3'(eidx);
        q8.push_back(e);
        req8  = v;
        rv8   = 1'b1;
        ordy8 = 1'b1;
        @(posedge clk); #1;
        rv8   = 1'b0;
    endtask

    task automatic issue5(input logic [4:0] v, input int eidx);
        exp_t e;
        e.none = (eidx < 0);
        e.idx  = (eidx < 0) ? 3'd0 : 3'(eidx);
        q5.push_back(e);
        req5  = v;
        rv5   = 1'b1;
        ordy5 = 1'b1;
        @(posedge clk); #1;
        rv5   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] sv [5];
        int         se [5];
        int         rre[5];

        sv = '{8'b01100011, 8'b00000011, 8'b00011011, 8'b11100011, 8'b00000001};
`ifdef PENC_ROUND_ROBIN_EN
        se  = '{6, 1, 0, 7, 0};
        rre = '{6, 5, 1, 0, 6};
`else
        se  = '{6, 1, 4, 7, 0};
        rre = '{6, 6, 6, 6, 6};
`endif

        // Reset state (req_ready is 1 while rst is high).
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid",  32'(ov8),   32'd0);
        chk("rst_out_idx",    32'(idx8),  32'd0);
        chk("rst_out_onehot", 32'(oh8),   32'd0);
        chk("rst_out_none",   32'(none8), 32'd0);
        chk("rst_req_ready",  32'(rr8),   32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Streaming with out_ready high: out_valid stays up back to back.
        for (int i = 0; i < 5; i++) begin
            issue8(sv[i], se[i]);
            chk("stream_out_valid", 32'(ov8), 32'd1);
        end

        // Zero vector: accepted, out_none result for one cycle.
        issue8(8'b00000000, -1);
        chk("zero_out_valid", 32'(ov8), 32'd1);
        @(posedge clk); #1;
        chk("zero_then_idle", 32'(ov8), 32'd0);

        // Repeated vector: rotation (or fixed priority).
        for (int i = 0; i < 5; i++) begin
            issue8(8'b01100011, rre[i]);
        end
        @(posedge clk); #1;

        // Backpressure: hold 4, refuse 10000000 until out_ready rises.
        issue8(8'b00010011, 4);
        ordy8 = 1'b0;
        req8  = 8'b10000000;
        rv8   = 1'b1;
        #0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_req_ready",  32'(rr8),  32'd0);
            chk("bp_out_idx",    32'(idx8), 32'd4);
            chk("bp_out_onehot", 32'(oh8),  32'h10);
            @(posedge clk); #1;
        end
        begin
            exp_t e;
            e.none = 1'b0;
            e.idx  = 3'd7;
            q8.push_back(e);
        end
        ordy8 = 1'b1;
        @(posedge clk); #1;
        chk("bp_refill_valid", 32'(ov8),  32'd1);
        chk("bp_refill_idx",   32'(idx8), 32'd7);
        rv8 = 1'b0;
        @(posedge clk); #1;

        // Reset with a pending result: it must vanish.
        req8  = 8'b00000100;
        rv8   = 1'b1;
        ordy8 = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_valid", 32'(ov8), 32'd1);
        rv8 = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_valid",  32'(ov8),   32'd0);
        chk("mid_rst_idx",    32'(idx8),  32'd0);
        chk("mid_rst_onehot", 32'(oh8),   32'd0);
        chk("mid_rst_none",   32'(none8), 32'd0);
        ordy8 = 1'b1;
        issue8(8'b01100011, 6);
        @(posedge clk); #1;

        // Non-power-of-2 width.
        issue5(5'b10110, 4);
        issue5(5'b00001, 0);
        issue5(5'b00000, -1);

        // Bounded drain.
        ordy8 = 1'b1;
        ordy5 = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (q8.size() == 0 && q5.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("n8_queue_empty", 32'(q8.size()), 32'd0);
        chk("n5_queue_empty", 32'(q5.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
